imem_loader: RTL and testbench

Program loader that fills the manquehuito instruction memory from a byte stream before the core runs. It sits between an external byte source (UART receiver or test harness) and the instruction memory write port. It holds the core in reset while loading and releases it only after a complete, well-formed image has been written. This is the write side of the instruction-memory path, whose literal field the datapath operand mux later reads back.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream (len, {opc,lit} pairs) and holds the core in reset until done.
// Latency: each word is written one cycle after its literal byte; done_o rises with the last write (optional IMEM_LOADER_CHECKSUM_EN adds a checksum byte).
// Backpressure: byte_ready_o is high only while loading; byte_valid_i low simply stalls, with no timeout.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 7,
  parameter int LIT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_valid_i,
  output logic                    byte_ready_o,
  output logic                    imem_we_o,
  output logic [ADDR_W-1:0]       imem_addr_o,
  output logic [OPC_W+LIT_W-1:0]  imem_data_o,
  output logic                    cpu_rst_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o
);

  typedef enum logic [2:0] {
    IDLE, LEN, OPC, LIT, DONE, ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [8:0]        rem_q;
  logic [OPC_W-1:0]  opc_q;
  logic [8:0]        len_w;
  logic              len_bad;
  logic              last_word;
  logic              accept;
  logic              can_start;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  // A length byte of zero stands for a full 256-word image.
  assign len_w     = (byte_i == 8'd0) ? 9'd256 : {1'b0, byte_i};
  assign len_bad   = 32'(len_w) > MAX_WORDS;
  assign last_word = (rem_q == 9'd1);
  assign accept    = byte_valid_i && byte_ready_o;
  assign can_start = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    cpu_rst_o    = 1'b1;
    case (state_q)
      IDLE, DONE, ERR: begin
        done_o    = (state_q == DONE);
        error_o   = (state_q == ERR);
        cpu_rst_o = (state_q != DONE);
        if (start_i) state_d = LEN;
      end
      LEN: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) state_d = len_bad ? ERR : OPC;
      end
      OPC: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) state_d = byte_i[7] ? ERR : LIT;
      end
      LIT: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = last_word ? CHK : OPC;
`else
          state_d = last_word ? DONE : OPC;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) state_d = ((csum_q ^ byte_i) == 8'd0) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over a literal accepted on the same edge, so no stray strobe follows.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      addr_cnt_q  <= '0;
      rem_q       <= '0;
      opc_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      imem_we_o <= 1'b0;
      if (can_start && start_i) begin
        addr_cnt_q <= '0;
        rem_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end
      if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ byte_i;
`endif
        case (state_q)
          LEN: rem_q <= len_w;
          OPC: opc_q <= byte_i[OPC_W-1:0];
          LIT: begin
            imem_we_o   <= 1'b1;
            imem_addr_o <= addr_cnt_q;
            imem_data_o <= {opc_q, byte_i[LIT_W-1:0]};
            addr_cnt_q  <= addr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_q       <= rem_q - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a queue-based image model.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [14:0] imem_data_o;
  logic        cpu_rst_o, busy_o, done_o, error_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0]  img_opc [256];
  logic [7:0]  img_lit [256];
  logic [22:0] got_q [$];
  logic [22:0] exp_q [$];
  logic [7:0]  csum;

  imem_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) if (imem_we_o) got_q.push_back({imem_addr_o, imem_data_o});

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        byte_valid_i = 1'b0;
        start_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
      end
      start_i = 1'($urandom_range(0, 1));
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && guard < 50) begin @(negedge clk_i); guard++; end
    checks++;
    if (guard >= 50) begin errors++; $display("FAIL ready_timeout got ready=0 want ready=1"); end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if ({byte_ready_o, busy_o, done_o, error_o, cpu_rst_o} !== 5'b11001) begin
      errors++;
      $display("FAIL start_state got rdy/busy/done/err/crst=%b want 11001",
               {byte_ready_o, busy_o, done_o, error_o, cpu_rst_o});
    end
  endtask

  // Streams img_* words 0..n-1 and checks timing of the final write and the written contents.
  task automatic load_image(input int n, input bit rnd);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), img_opc[i], img_lit[i]});
    csum = 8'(n);
    send_byte(8'(n), rnd);
    for (int i = 0; i < n; i++) begin
      send_byte({1'b0, img_opc[i]}, rnd);
      csum = csum ^ {1'b0, img_opc[i]};
      if (i == n - 1) begin
        send_byte(img_lit[i], 1'b0);
      end else begin
        send_byte(img_lit[i], rnd);
      end
      csum = csum ^ img_lit[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if ({imem_we_o, done_o, cpu_rst_o} !== 3'b101) begin
      errors++; $display("FAIL last_write_chk got we/done/crst=%b want 101", {imem_we_o, done_o, cpu_rst_o});
    end
    send_byte(csum, 1'b0);
    checks++;
    if ({done_o, cpu_rst_o, error_o} !== 3'b100) begin
      errors++; $display("FAIL chk_done got done/crst/err=%b want 100", {done_o, cpu_rst_o, error_o});
    end
`else
    checks++;
    if ({imem_we_o, done_o, cpu_rst_o, busy_o} !== 4'b1100) begin
      errors++;
      $display("FAIL last_write got we/done/crst/busy=%b want 1100", {imem_we_o, done_o, cpu_rst_o, busy_o});
    end
`endif
    @(negedge clk_i);
    checks++;
    if (imem_we_o !== 1'b0) begin errors++; $display("FAIL we_pulse got we=%b want 0", imem_we_o); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL write_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL write_%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({done_o, cpu_rst_o, error_o, byte_ready_o} !== 4'b1000) begin
      errors++; $display("FAIL done_level got done/crst/err/rdy=%b want 1000", {done_o, cpu_rst_o, error_o, byte_ready_o});
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      img_opc[i] = 7'($urandom);
      img_lit[i] = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    got_q.delete();
    checks++;
    if ({byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, error_o} !==
        {1'b0, 1'b0, 8'h00, 15'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values got rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b",
               byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, error_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({cpu_rst_o, byte_ready_o, imem_we_o} !== 3'b100) begin
        errors++; $display("FAIL idle_%0d got crst/rdy/we=%b want 100", i, {cpu_rst_o, byte_ready_o, imem_we_o});
      end
    end
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL idle_writes got %0d want 0", got_q.size()); end
  endtask

  task automatic test_basic();
    img_opc[0] = 7'h05; img_lit[0] = 8'h3C;
    img_opc[1] = 7'h7F; img_lit[1] = 8'hA1;
    do_start();
    load_image(2, 1'b0);
  endtask

  task automatic test_error();
    do_start();
    got_q.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h85, 1'b0);
    checks++;
    if ({error_o, byte_ready_o, imem_we_o, cpu_rst_o, done_o} !== 5'b10010) begin
      errors++; $display("FAIL bad_opcode got err/rdy/we/crst/done=%b want 10010",
               {error_o, byte_ready_o, imem_we_o, cpu_rst_o, done_o});
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (got_q.size() !== 0 || error_o !== 1'b1) begin
      errors++; $display("FAIL err_hold got writes=%0d err=%b want 0 1", got_q.size(), error_o);
    end
    fill_random(5);
    do_start();
    load_image(5, 1'b1);
  endtask

  task automatic test_full_image();
    fill_random(256);
    do_start();
    load_image(256, 1'b1);
  endtask

  task automatic test_random_images();
    for (int k = 0; k < 4; k++) begin
      int n = $urandom_range(1, 20);
      fill_random(n);
      do_start();
      load_image(n, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int n = 6;
    fill_random(n);
    do_start();
    c0 = cyc;
    load_image(n, 1'b0);
    checks++;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (cyc - c0 !== 2 * n + 3) begin
      errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc - c0, 2 * n + 3);
    end
`else
    if (cyc - c0 !== 2 * n + 2) begin
      errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc - c0, 2 * n + 2);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    fill_random(3);
    do_start();
    got_q.delete();
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_byte({1'b0, img_opc[i]}, 1'b0);
      send_byte(img_lit[i], 1'b0);
    end
    send_byte({1'b0, img_opc[2]}, 1'b0);
    byte_i = img_lit[2];
    byte_valid_i = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    byte_valid_i = 1'b0;
    checks++;
    if ({byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, error_o} !==
        {1'b0, 1'b0, 8'h00, 15'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b",
               byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, error_o);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL mid_reset_writes got %0d want 2", got_q.size()); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if ({error_o, done_o, cpu_rst_o} !== 3'b101) begin
      errors++; $display("FAIL chk_bad got err/done/crst=%b want 101", {error_o, done_o, cpu_rst_o});
    end
    img_opc[0] = 7'h12; img_lit[0] = 8'h34;
    do_start();
    load_image(1, 1'b0);
  endtask
`endif

  initial begin
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_error();
    test_back_to_back();
    test_random_images();
    test_full_image();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got time=%0t want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
